arbitro_rr_param: RTL and testbench

//   Parametrised arbiter between N_IN input FIFOs and N_OUT output FIFOs. Pops one word per

---
 rtl/arbitro_rr_param.sv | 115 +++++++++++
 tb/tb_arbitro_rr_param.sv | 135 +++++++++++++
 2 files changed

// File: rtl/arbitro_rr_param.sv
// Arbiter moving words from N_IN input FIFOs to N_OUT output FIFOs, routed by a destination field.
// Fixed-priority or round-robin grant with a pop -> capture -> push pipeline.
module arbitro_rr_param #(
    parameter int N_IN     = 4,
    parameter int N_OUT    = 4,
    parameter int DATA_W   = 6,
    parameter int DEST_LSB = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [N_IN-1:0]          empties,
    input  logic [N_OUT-1:0]         almost_full,
    input  logic [N_IN*DATA_W-1:0]   data_in,
    output logic [N_IN-1:0]          pop,
    output logic [N_OUT-1:0]         push,
    output logic [DATA_W-1:0]        data_out,
    output logic                     dest_err,
    output logic [1:0]               state
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int DW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t            state_r, state_nxt;
    logic [IW-1:0]     rr_ptr;
    logic [N_IN-1:0]   elig;
    logic              gnt_vld;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     idx_p0, idx_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] word_p1;
    logic [DW-1:0]     dest_p1;

    assign state = state_r;

    // Grant decision; a channel popped this cycle is masked because its empty flag lags by one cycle
    always_comb begin
        elig    = ~empties & ~pop;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state_r != S_INIT && !(|almost_full)) begin
            if (!mode) begin
                for (int i = N_IN-1; i >= 0; i--) begin
                    if (elig[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = IW'(i);
                    end
                end
            end else begin
                for (int j = N_IN-1; j >= 0; j--) begin
                    if (elig[(int'(rr_ptr) + j) % N_IN]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = IW'((int'(rr_ptr) + j) % N_IN);
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = S_INIT;
        case (state_r)
            S_INIT:   state_nxt = S_IDLE;
            S_IDLE,
            S_ACTIVE: state_nxt = gnt_vld ? S_ACTIVE : S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    assign word_p1 = data_in[int'(idx_p1)*DATA_W +: DATA_W];
    assign dest_p1 = word_p1[DEST_LSB +: DW];

    // Stage p0: pop strobe; stage p1: FIFO read data valid; stage p2: push toward the output FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_INIT;
            rr_ptr   <= '0;
            pop      <= '0;
            vld_p1   <= 1'b0;
            push     <= '0;
            data_out <= '0;
            dest_err <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            pop      <= gnt_vld ? ({{(N_IN-1){1'b0}}, 1'b1} << gnt_idx) : '0;
            if (gnt_vld)
                rr_ptr <= (int'(gnt_idx) == N_IN-1) ? '0 : gnt_idx + IW'(1);
            vld_p1   <= |pop;
            push     <= '0;
            dest_err <= 1'b0;
            if (vld_p1) begin
                if (int'(dest_p1) < N_OUT) begin
                    push     <= {{(N_OUT-1){1'b0}}, 1'b1} << dest_p1;
                    data_out <= word_p1;
                end else begin
                    dest_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_vld)
            idx_p0 <= gnt_idx;
        idx_p1 <= idx_p0;
    end

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Directed bench for arbitro_rr_param: a 4x4 instance plus a 4x3 instance sharing the stimulus
// so that a destination of 3 is out of range on the second one.
module tb_arbitro_rr_param;

    localparam logic [5:0] W0 = 6'b01_0000;
    localparam logic [5:0] W1 = 6'b10_0001;
    localparam logic [5:0] W2 = 6'b11_0010;
    localparam logic [5:0] W3 = 6'b00_0011;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [3:0]  empties;
    logic [3:0]  almost_full;
    logic [23:0] data_in;
    logic [3:0]  pop, pop3;
    logic [3:0]  push;
    logic [2:0]  push3;
    logic [5:0]  data_out, data_out3;
    logic        dest_err, dest_err3;
    logic [1:0]  state, state3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arbitro_rr_param #(.N_IN(4), .N_OUT(4), .DATA_W(6), .DEST_LSB(4)) dut (
        .clk(clk), .reset(reset), .mode(mode), .empties(empties),
        .almost_full(almost_full), .data_in(data_in), .pop(pop), .push(push),
        .data_out(data_out), .dest_err(dest_err), .state(state)
    );

    arbitro_rr_param #(.N_IN(4), .N_OUT(3), .DATA_W(6), .DEST_LSB(4)) dut3 (
        .clk(clk), .reset(reset), .mode(mode), .empties(empties),
        .almost_full(almost_full[2:0]), .data_in(data_in), .pop(pop3), .push(push3),
        .data_out(data_out3), .dest_err(dest_err3), .state(state3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] ep, input logic [3:0] eu,
                        input logic [5:0] ed, input logic [1:0] es);
        tick();
        check({tag, " pop"},   32'(pop),      32'(ep));
        check({tag, " push"},  32'(push),     32'(eu));
        check({tag, " dout"},  32'(data_out), 32'(ed));
        check({tag, " state"}, 32'(state),    32'(es));
        check({tag, " derr"},  32'(dest_err), 32'(0));
    endtask

    initial begin
        reset       = 1'b1;
        mode        = 1'b0;
        empties     = 4'b1111;
        almost_full = 4'b0000;
        data_in     = {W3, W2, W1, W0};

        // reset held for three cycles
        step("rst1", 4'b0000, 4'b0000, 6'd0, 2'd0);
        step("rst2", 4'b0000, 4'b0000, 6'd0, 2'd0);
        step("rst3", 4'b0000, 4'b0000, 6'd0, 2'd0);
        reset = 1'b0;
        step("init", 4'b0000, 4'b0000, 6'd0, 2'd1);

        // fixed priority: ch0 masked after each pop, so ch0/ch1 alternate
        empties = 4'b0000;
        step("fp1", 4'b0001, 4'b0000, 6'd0, 2'd2);
        step("fp2", 4'b0010, 4'b0000, 6'd0, 2'd2);
        step("fp3", 4'b0001, 4'b0010, W0,   2'd2);
        step("fp4", 4'b0010, 4'b0100, W1,   2'd2);
        empties = 4'b1111;
        step("fp5", 4'b0000, 4'b0010, W0,   2'd1);
        step("fp6", 4'b0000, 4'b0100, W1,   2'd1);
        step("fp7", 4'b0000, 4'b0000, W1,   2'd1);

        // round robin from a fresh reset
        reset = 1'b1;
        step("rst4", 4'b0000, 4'b0000, 6'd0, 2'd0);
        reset   = 1'b0;
        mode    = 1'b1;
        empties = 4'b0000;
        step("rr0", 4'b0000, 4'b0000, 6'd0, 2'd1);
        step("rr1", 4'b0001, 4'b0000, 6'd0, 2'd2);
        step("rr2", 4'b0010, 4'b0000, 6'd0, 2'd2);
        step("rr3", 4'b0100, 4'b0010, W0,   2'd2);
        step("rr4", 4'b1000, 4'b0100, W1,   2'd2);
        check("n3 push rr4", 32'(push3),     32'(3'b100));
        check("n3 derr rr4", 32'(dest_err3), 32'(0));
        step("rr5", 4'b0001, 4'b1000, W2,   2'd2);
        check("n3 push rr5", 32'(push3),     32'(3'b000));
        check("n3 derr rr5", 32'(dest_err3), 32'(1));
        check("n3 dout rr5", 32'(data_out3), 32'(W1));
        step("rr6", 4'b0010, 4'b0001, W3,   2'd2);
        check("n3 push rr6", 32'(push3),     32'(3'b001));
        check("n3 derr rr6", 32'(dest_err3), 32'(0));

        // stall: in-flight words still drain, rr order resumes at ch2
        almost_full = 4'b0010;
        step("af1", 4'b0000, 4'b0010, W0,   2'd1);
        step("af2", 4'b0000, 4'b0100, W1,   2'd1);
        step("af3", 4'b0000, 4'b0000, W1,   2'd1);
        almost_full = 4'b0000;
        step("af4", 4'b0100, 4'b0000, W1,   2'd2);
        step("af5", 4'b1000, 4'b0000, W1,   2'd2);
        step("af6", 4'b0001, 4'b1000, W2,   2'd2);

        // reset the cycle after a pop: in-flight words dropped, rr_ptr back to 0
        reset   = 1'b1;
        empties = 4'b1111;
        step("rs1", 4'b0000, 4'b0000, 6'd0, 2'd0);
        reset = 1'b0;
        step("rs2", 4'b0000, 4'b0000, 6'd0, 2'd1);
        empties = 4'b0000;
        step("rs3", 4'b0001, 4'b0000, 6'd0, 2'd2);
        empties = 4'b1111;
        step("rs4", 4'b0000, 4'b0000, 6'd0, 2'd1);
        step("rs5", 4'b0000, 4'b0010, W0,   2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
